// File: rtl/vga_sync_gen_pkg.sv
// Default 640x480@60 raster timing shared by the sync generator and downstream stages.
// Stages that only need the visible area import DEF_H_DISPLAY / DEF_V_DISPLAY from here.
package vga_sync_gen_pkg;

  localparam int PIX_W = 10;

  localparam int DEF_TICK_DIV  = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int DEF_VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

  // Inclusive unsigned window test used for both sync pulses.
  function automatic logic in_window(input logic [PIX_W-1:0] v,
                                     input logic [PIX_W-1:0] lo,
                                     input logic [PIX_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick.sv
// Mod-TICK_DIV counter; p_tick is high for the one clk where the count sits at TICK_DIV-1.
// TICK_DIV is expected to be >= 2 so that p_tick reads 0 while held in reset.
module pixel_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  assign p_tick = (tick_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing source: pixel tick, h/v counters and sync/blank decode, all registered
// on the same p_tick edge so pixel_x/pixel_y/video_on/hsync/vsync describe one pixel.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             p_tick,
  output logic [PIX_W-1:0] pixel_x,
  output logic [PIX_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [PIX_W-1:0] H_LAST   = PIX_W'(H_TOTAL - 1);
  localparam logic [PIX_W-1:0] V_LAST   = PIX_W'(V_TOTAL - 1);
  localparam logic [PIX_W-1:0] H_VIS    = PIX_W'(H_DISPLAY);
  localparam logic [PIX_W-1:0] V_VIS    = PIX_W'(V_DISPLAY);
  localparam logic [PIX_W-1:0] HS_START = PIX_W'(H_DISPLAY + H_FRONT);
  localparam logic [PIX_W-1:0] HS_END   = PIX_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [PIX_W-1:0] VS_START = PIX_W'(V_DISPLAY + V_FRONT);
  localparam logic [PIX_W-1:0] VS_END   = PIX_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [PIX_W-1:0] x_next;
  logic [PIX_W-1:0] y_next;
  logic             h_wrap;
  logic             v_wrap;

  pixel_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_pixel_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (p_tick)
  );

  always_comb begin
    h_wrap = (pixel_x == H_LAST);
    v_wrap = (pixel_y == V_LAST);
    x_next = h_wrap ? '0 : pixel_x + PIX_W'(1);
    y_next = pixel_y;
    if (h_wrap) begin
      y_next = v_wrap ? '0 : pixel_y + PIX_W'(1);
    end
  end

  // Decode from x_next/y_next so the flags land on the same edge as the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (p_tick) begin
        pixel_x     <= x_next;
        pixel_y     <= y_next;
        video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
        hsync       <= !in_window(x_next, HS_START, HS_END);
        vsync       <= !in_window(y_next, VS_START, VS_END);
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

endmodule
